// File: rtl/prim_shadow_reg_ctrl.sv
// Shadowed configuration register: a value commits only after two matching
// consecutive writes, and the committed/inverted-shadow pair is cross-checked every cycle.
module prim_shadow_reg_ctrl #(
  parameter int               Width      = 32,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [Width-1:0] wd_i,
  input  logic             re_i,
  output logic [Width-1:0] q_o,
  output logic [Width-1:0] qs_o,
  output logic             qe_o,
  output logic             phase_o,
  output logic             err_update_o,
  output logic             err_storage_o
);

  // state  | meaning
  // IDLE   | awaiting first write (phase 0)
  // STAGED | first write held in staging flop, awaiting matching second write (phase 1)
  typedef enum logic {
    IDLE   = 1'b0,
    STAGED = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [Width-1:0] staged_q, staged_d;
  logic [Width-1:0] committed_q, committed_d;
  logic [Width-1:0] shadow_q, shadow_d;
  logic             qe_q, qe_d;
  logic             err_update_q, err_update_d;
  logic             err_storage_q;
  logic             storage_mismatch;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      staged_q     <= '0;
      committed_q  <= ResetValue;
      shadow_q     <= ~ResetValue;
      qe_q         <= 1'b0;
      err_update_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      staged_q     <= staged_d;
      committed_q  <= committed_d;
      shadow_q     <= shadow_d;
      qe_q         <= qe_d;
      err_update_q <= err_update_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    staged_d     = staged_q;
    committed_d  = committed_q;
    shadow_d     = shadow_q;
    qe_d         = 1'b0;
    err_update_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (we_i) begin
          staged_d = wd_i;
          state_d  = STAGED;
        end
      end
      STAGED: begin
        // A write always wins over a simultaneous read strobe.
        if (we_i) begin
          state_d = IDLE;
          if (wd_i == staged_q) begin
            committed_d = wd_i;
            shadow_d    = ~wd_i;
            qe_d        = 1'b1;
          end else begin
            staged_d     = '0;
            err_update_d = 1'b1;
          end
        end else if (re_i) begin
          staged_d = '0;
          state_d  = IDLE;
        end
      end
      default: begin
        staged_d = '0;
        state_d  = IDLE;
      end
    endcase
  end

  assign storage_mismatch = (committed_q != ~shadow_q);

  // Sticky until reset; commits keep working after a fault is flagged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_storage_q <= 1'b0;
    end else if (storage_mismatch) begin
      err_storage_q <= 1'b1;
    end
  end

  assign q_o           = committed_q;
  assign qs_o          = committed_q;
  assign qe_o          = qe_q;
  assign phase_o       = (state_q == STAGED);
  assign err_update_o  = err_update_q;
  assign err_storage_o = err_storage_q;

endmodule

// File: tb/tb_prim_shadow_reg_ctrl.sv
// Directed bench for prim_shadow_reg_ctrl: double-write commit, mismatch, read abort,
// storage fault injection and asynchronous reset while staged.
module tb_prim_shadow_reg_ctrl;

  localparam logic [31:0] RstVal = 32'h0000_00A5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [31:0] wd;
  logic        re;
  logic [31:0] q;
  logic [31:0] qs;
  logic        qe;
  logic        phase;
  logic        err_update;
  logic        err_storage;

  int checks   = 0;
  int failures = 0;

  prim_shadow_reg_ctrl #(
    .Width      (32),
    .ResetValue (RstVal)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .we_i          (we),
    .wd_i          (wd),
    .re_i          (re),
    .q_o           (q),
    .qs_o          (qs),
    .qe_o          (qe),
    .phase_o       (phase),
    .err_update_o  (err_update),
    .err_storage_o (err_storage)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, return 1 time unit after the rising edge.
  task automatic step(input logic w, input logic [31:0] d, input logic r);
    @(negedge clk);
    we = w;
    wd = d;
    re = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string tag, input logic ph, input logic e_qe,
                           input logic e_upd, input logic e_sto);
    chk({tag, "_phase"}, {31'd0, phase}, {31'd0, ph});
    chk({tag, "_qe"}, {31'd0, qe}, {31'd0, e_qe});
    chk({tag, "_err_update"}, {31'd0, err_update}, {31'd0, e_upd});
    chk({tag, "_err_storage"}, {31'd0, err_storage}, {31'd0, e_sto});
  endtask

  initial begin
    rst_n = 1'b0;
    we    = 1'b0;
    wd    = '0;
    re    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", q, RstVal);
    chk("rst_qs", qs, RstVal);
    chk_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Matching pair commits one cycle after the second strobe.
    step(1'b1, 32'hDEAD_BEEF, 1'b0);
    chk("w1_q", q, RstVal);
    chk_flags("w1", 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hDEAD_BEEF, 1'b0);
    chk("w2_q", q, 32'hDEAD_BEEF);
    chk("w2_qs", qs, 32'hDEAD_BEEF);
    chk_flags("w2", 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    chk("w2_hold_q", q, 32'hDEAD_BEEF);
    chk_flags("w2_hold", 1'b0, 1'b0, 1'b0, 1'b0);

    // Mismatching second write.
    step(1'b1, 32'h1234_5678, 1'b0);
    chk_flags("mm1", 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h1234_5679, 1'b0);
    chk("mm2_q", q, 32'hDEAD_BEEF);
    chk_flags("mm2", 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    chk_flags("mm_hold", 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h1, 1'b0);
    step(1'b1, 32'h1, 1'b0);
    chk("one_q", q, 32'h1);
    chk_flags("one", 1'b0, 1'b1, 1'b0, 1'b0);

    // Read aborts a pending first write; the next write restarts staging.
    step(1'b1, 32'hCAFE_0000, 1'b0);
    chk_flags("ab1", 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    chk_flags("ab_rd", 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hCAFE_0000, 1'b0);
    chk("ab2_q", q, 32'h1);
    chk_flags("ab2", 1'b1, 1'b0, 1'b0, 1'b0);
    // Write plus read together: write wins and commits.
    step(1'b1, 32'hCAFE_0000, 1'b1);
    chk("wr_rd_q", q, 32'hCAFE_0000);
    chk_flags("wr_rd", 1'b0, 1'b1, 1'b0, 1'b0);
    // Read in IDLE has no effect.
    step(1'b0, 32'h0, 1'b1);
    chk("idle_rd_q", q, 32'hCAFE_0000);
    chk_flags("idle_rd", 1'b0, 1'b0, 1'b0, 1'b0);

    // Storage fault: flip shadow bit 3 after committing FFFF_0000.
    step(1'b1, 32'hFFFF_0000, 1'b0);
    step(1'b1, 32'hFFFF_0000, 1'b0);
    chk("sf_commit_q", q, 32'hFFFF_0000);
    step(1'b0, 32'h0, 1'b0);
    chk_flags("sf_pre", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    force dut.shadow_q = 32'h0000_FFF7;
    @(posedge clk);
    #1;
    chk("sf_set", {31'd0, err_storage}, 32'd1);
    step(1'b0, 32'h0, 1'b0);
    release dut.shadow_q;
    step(1'b1, 32'h0000_0077, 1'b0);
    step(1'b1, 32'h0000_0077, 1'b0);
    chk("sf_commit2_q", q, 32'h0000_0077);
    chk_flags("sf_commit2", 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    chk("sf_sticky", {31'd0, err_storage}, 32'd1);

    // Asynchronous reset while staged.
    step(1'b1, 32'h0000_0009, 1'b0);
    chk("ar_pre_phase", {31'd0, phase}, 32'd1);
    @(negedge clk);
    we = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_q", q, RstVal);
    chk_flags("ar", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'h5, 1'b0);
    chk("ar_w_q", q, RstVal);
    chk_flags("ar_w", 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    chk("ar_w_hold_q", q, RstVal);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prim_shadow_reg_ctrl.md
Name: prim_shadow_reg_ctrl

Overview:
Controller that sequences a group of flop stages into one shadowed configuration register: a staging flop, a committed flop and an inverted shadow flop. A value is committed only after two matching consecutive writes. Committed and shadow copies are cross-checked every cycle to detect storage faults. Sits between the register interface write path and security-critical configuration outputs.

Parameters:
Width, 32, data width of every stage.
ResetValue, '0, reset value of the committed stage; the shadow stage resets to ~ResetValue.

Ports:
clk_i  input  1  clock.
rst_ni  input  1  reset, asynchronous, active-low.
we_i  input  1  write strobe, one cycle per bus write.
wd_i  input  Width  write data, valid when we_i=1.
re_i  input  1  read strobe from the bus; aborts a pending first write.
q_o  output  Width  committed value to hardware.
qs_o  output  Width  value returned on bus reads; equals the committed stage.
qe_o  output  1  one-cycle pulse in the first cycle q_o shows a newly committed value.
phase_o  output  1  0 = awaiting first write, 1 = awaiting second write.
err_update_o  output  1  one-cycle pulse when the second write mismatches the staged value.
err_storage_o  output  1  sticky storage-fault flag.

Behaviour:
- Interface: one clock, clk_i. Reset rst_ni is asynchronous and active-low. All state is held in flops with asynchronous clear/preset on rst_ni low.
- Reset values:
  - staged = '0; committed = ResetValue; shadow = ~ResetValue.
  - q_o = qs_o = ResetValue.
  - phase_o = 0, qe_o = 0, err_update_o = 0, err_storage_o = 0.
- The FSM has two states, IDLE (phase 0) and STAGED (phase 1).
- IDLE, we_i=1: staged <= wd_i; next state STAGED. Committed and shadow stages are unchanged.
- IDLE, re_i=1 with we_i=0: no effect.
- STAGED, we_i=1 and wd_i == staged:
  - committed <= wd_i; shadow <= ~wd_i.
  - qe_o = 1 in the next cycle, for exactly one cycle.
  - Next state IDLE.
- STAGED, we_i=1 and wd_i != staged:
  - No commit.
  - err_update_o = 1 in the next cycle, for exactly one cycle.
  - staged <= '0; next state IDLE.
- STAGED, re_i=1 with we_i=0: abort. staged <= '0; next state IDLE; no error is raised.
- Simultaneous we_i and re_i: the write takes precedence and re_i is ignored.
- Latency: q_o changes 1 cycle after the second write strobe. qe_o and err_update_o are registered and aligned with that same cycle.
- Storage check, every cycle:
  - mismatch = (committed != ~shadow).
  - If mismatch, err_storage_o <= 1.
  - Once set, err_storage_o stays at 1 until reset. Writes and reads do not clear it.
  - Commits continue to operate normally after a storage error.
- Reset mid-operation: rst_ni low in STAGED returns immediately (asynchronously) to IDLE with all reset values. A following single write must not commit.
- No other states exist. An illegal state encoding (if encoded wider than 1 bit) returns to IDLE and clears staged.
- Width arithmetic: equality and inversion are bitwise over the full Width. There is no truncation.

Test Plan:
- Reset with ResetValue=32'h0000_00A5 -> q_o=32'h0000_00A5, phase_o=0, both error outputs 0, qe_o=0.
- Write 32'hDEAD_BEEF twice on consecutive strobes -> phase_o goes 0→1→0. q_o=32'hDEAD_BEEF one cycle after the second strobe. qe_o pulses once in that cycle.
- Write 32'h1234_5678, then 32'h1234_5679 -> err_update_o pulses once, q_o unchanged, phase_o back to 0. A subsequent matching pair 32'h1 / 32'h1 commits 32'h1.
- Write 32'hCAFE_0000, then read (re_i), then write 32'hCAFE_0000 -> no commit, phase_o=1 after the final write, no error pulse.
- Force shadow bit 3 to flip after committing 32'hFFFF_0000 -> err_storage_o=1 on the next cycle. It stays 1 through further commits and reads, and clears only on rst_ni low.
- Assert rst_ni low asynchronously while phase_o=1 -> outputs return to reset values before the next clock edge. A single write of 32'h5 afterwards leaves q_o=ResetValue and phase_o=1.
